// File: rtl/mastermind_scorer.sv
// Mastermind feedback engine: scores a latched guess against a latched code (red/white) and
// tracks guess count, win and game-over. Result in PEGS + 2**COLOR_W + 1 cycles; start ignored while busy/game over.
module mastermind_scorer #(
   parameter  int PEGS        = 4,
   parameter  int COLOR_W     = 3,
   parameter  int MAX_GUESSES = 8,
   localparam int CNT_W       = $clog2(PEGS + 1),
   localparam int GC_W        = $clog2(MAX_GUESSES + 1)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      start_i,
   input  logic                      new_game_i,
   input  logic [PEGS*COLOR_W-1:0]   code_i,
   input  logic [PEGS*COLOR_W-1:0]   guess_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [CNT_W-1:0]          red_o,
   output logic [CNT_W-1:0]          white_o,
   output logic [GC_W-1:0]           guess_count_o,
   output logic                      win_o,
   output logic                      game_over_o
);

   localparam int NCOL   = 1 << COLOR_W;
   localparam int PIDX_W = (PEGS > 1) ? $clog2(PEGS) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, TALLY, DONE} state_t;

   state_t               state_q, state_d;
   logic [COLOR_W-1:0]   code_q       [PEGS];
   logic [COLOR_W-1:0]   guess_q      [PEGS];
   logic [CNT_W-1:0]     code_hist_q  [NCOL];
   logic [CNT_W-1:0]     guess_hist_q [NCOL];
   logic [PIDX_W-1:0]    pidx_q;
   logic [COLOR_W-1:0]   cidx_q;
   logic [CNT_W-1:0]     red_acc_q, white_acc_q;
   logic [CNT_W-1:0]     red_q, white_q;
   logic [GC_W-1:0]      gc_q;
   logic                 win_q, over_q;

   logic                 accept;
   logic                 last_peg, last_col;
   logic [CNT_W-1:0]     hist_min, white_fin;
   logic [GC_W-1:0]      gc_inc;
   logic                 win_fin;

   always_comb begin
      accept    = (state_q == IDLE) && start_i && !new_game_i && !over_q;
      last_peg  = (pidx_q == PIDX_W'(PEGS - 1));
      last_col  = (cidx_q == {COLOR_W{1'b1}});
      hist_min  = (code_hist_q[cidx_q] < guess_hist_q[cidx_q]) ?
                  code_hist_q[cidx_q] : guess_hist_q[cidx_q];
      white_fin = white_acc_q + hist_min;
      gc_inc    = (gc_q == GC_W'(MAX_GUESSES)) ? gc_q : gc_q + GC_W'(1);
      win_fin   = (red_acc_q == CNT_W'(PEGS));
   end

   always_ff @(posedge clk) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE:  if (accept) state_d = SCAN;
         SCAN:  begin
            busy_o = 1'b1;
            if (last_peg) state_d = TALLY;
         end
         TALLY: begin
            busy_o = 1'b1;
            if (last_col) state_d = DONE;
         end
         DONE:  begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (new_game_i) state_d = IDLE;
   end

   // new_game clears the whole datapath just like reset, so an aborted score leaves no trace
   always_ff @(posedge clk) begin
      if (!resetn || new_game_i) begin
         for (int i = 0; i < PEGS; i++) begin
            code_q[i]  <= '0;
            guess_q[i] <= '0;
         end
         for (int c = 0; c < NCOL; c++) begin
            code_hist_q[c]  <= '0;
            guess_hist_q[c] <= '0;
         end
         pidx_q      <= '0;
         cidx_q      <= '0;
         red_acc_q   <= '0;
         white_acc_q <= '0;
         red_q       <= '0;
         white_q     <= '0;
         gc_q        <= '0;
         win_q       <= 1'b0;
         over_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               for (int i = 0; i < PEGS; i++) begin
                  code_q[i]  <= code_i[i*COLOR_W +: COLOR_W];
                  guess_q[i] <= guess_i[i*COLOR_W +: COLOR_W];
               end
               for (int c = 0; c < NCOL; c++) begin
                  code_hist_q[c]  <= '0;
                  guess_hist_q[c] <= '0;
               end
               pidx_q      <= '0;
               cidx_q      <= '0;
               red_acc_q   <= '0;
               white_acc_q <= '0;
            end
            SCAN: begin
               if (code_q[pidx_q] == guess_q[pidx_q]) begin
                  red_acc_q <= red_acc_q + CNT_W'(1);
               end else begin
                  code_hist_q[code_q[pidx_q]]   <= code_hist_q[code_q[pidx_q]] + CNT_W'(1);
                  guess_hist_q[guess_q[pidx_q]] <= guess_hist_q[guess_q[pidx_q]] + CNT_W'(1);
               end
               pidx_q <= last_peg ? '0 : pidx_q + PIDX_W'(1);
               cidx_q <= '0;
            end
            TALLY: begin
               white_acc_q <= white_fin;
               cidx_q      <= cidx_q + COLOR_W'(1);
               // Results and game state land on the edge into DONE so they are valid with done
               if (last_col) begin
                  red_q   <= red_acc_q;
                  white_q <= white_fin;
                  gc_q    <= gc_inc;
                  win_q   <= win_q | win_fin;
                  over_q  <= over_q | win_fin | (gc_inc == GC_W'(MAX_GUESSES));
               end
            end
            default: ;
         endcase
      end
   end

   assign red_o         = red_q;
   assign white_o       = white_q;
   assign guess_count_o = gc_q;
   assign win_o         = win_q;
   assign game_over_o   = over_q;

endmodule
